// File: rtl/dobby_bus_pkg.sv
// dobby_bus_pkg: shared encodings for the Dobby bus arbiter
//   SZ_BYTE/SZ_HALF/SZ_WORD  bus access size codes (2'b11 is illegal)
//   PORT_IF/PORT_LS          requester identifiers
//   state_t                  arbiter FSM states ST_IDLE/ST_XFER/ST_RESP
//   misaligned()             1 when a size/address pair cannot go on the bus
package dobby_bus_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return size == SZ_WORD ? |lsb : size == SZ_HALF ? lsb[0] : size != SZ_BYTE;
  endfunction
endpackage

// File: rtl/dobby_bus_arbiter_if.sv
// dobby_bus_arbiter_if: request ports of IF and LS plus the external bus pins
//   slave  - arbiter view (takes requests and bus_rdy_i, drives grants/done/bus_*)
//   master - requester/bus-slave view (the opposite directions)
interface dobby_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_done_o;
  logic              if_err_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req_i;
  logic              ls_we_i;
  logic [1:0]        ls_size_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_done_o;
  logic              ls_err_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              bus_en_o;
  logic              bus_we_o;
  logic [1:0]        bus_size_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_write_data_o;
  logic              bus_rdy_i;
  logic [DATA_W-1:0] bus_read_data_i;
  logic              busy_o;
  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
           bus_rdy_i, bus_read_data_i,
    output if_gnt_o, if_done_o, if_err_o, if_rdata_o, ls_gnt_o, ls_done_o, ls_err_o, ls_rdata_o,
           bus_en_o, bus_we_o, bus_size_o, bus_addr_o, bus_write_data_o, busy_o
  );
  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
           bus_rdy_i, bus_read_data_i,
    input  if_gnt_o, if_done_o, if_err_o, if_rdata_o, ls_gnt_o, ls_done_o, ls_err_o, ls_rdata_o,
           bus_en_o, bus_we_o, bus_size_o, bus_addr_o, bus_write_data_o, busy_o
  );
endinterface

// File: rtl/dobby_bus_timeout.sv
// dobby_bus_timeout: counts bus-phase cycles and flags the last allowed one
//   clk_i, a_reset_h_i  clock, asynchronous active-high reset
//   clr                 hold the count at zero (outside the bus phase)
//   run                 bus phase active without bus_rdy_i
//   expired             this is cycle TIMEOUT_CYCLES of the bus phase with no rdy
module dobby_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic a_reset_h_i,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or posedge a_reset_h_i) begin
    if (a_reset_h_i) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  end
  assign expired = run && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/dobby_bus_arbiter.sv
// dobby_bus_arbiter: shares the external bus between instruction fetch (IF) and load/store (LS)
//   clk_i        system clock
//   a_reset_h_i  asynchronous reset, active-high
//   bus          dobby_bus_arbiter_if.slave: IF/LS request ports and bus_* pins
// Optional: define DOBBY_BUS_TIMEOUT_EN to abort bus phases longer than TIMEOUT_CYCLES.
module dobby_bus_arbiter
  import dobby_bus_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit LS_FIRST       = 1'b1
) (
  input logic             clk_i,
  input logic             a_reset_h_i,
  dobby_bus_arbiter_if.slave bus
);
  state_t state, state_n;
  logic ptr, owner, err_q, sel, tie, any_req, grant, bad, expired;
  logic bus_we_q;
  logic [1:0] bus_size_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q, if_rdata_q, ls_rdata_q;
  assign any_req = bus.if_req_i | bus.ls_req_i;
  assign tie = bus.if_req_i & bus.ls_req_i;
  assign sel = tie ? ptr : (bus.ls_req_i ? PORT_LS : PORT_IF);
  assign bad = sel == PORT_LS ? misaligned(bus.ls_size_i, bus.ls_addr_i[1:0]) : |bus.if_addr_i[1:0];
  assign grant = state == ST_IDLE && any_req;
`ifdef DOBBY_BUS_TIMEOUT_EN
  dobby_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i,
    .a_reset_h_i,
    .clr(state != ST_XFER),
    .run(state == ST_XFER && !bus.bus_rdy_i),
    .expired
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge a_reset_h_i) begin
    if (a_reset_h_i) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = any_req ? (bad ? ST_RESP : ST_XFER) : ST_IDLE;
      ST_XFER: state_n = bus.bus_rdy_i || expired ? ST_RESP : ST_XFER;
      default: state_n = ST_IDLE;
    endcase
  end
  // Grants are combinational on req so that req->done is grant, XFER, RESP;
  // masked during reset so every output reads 0 while it is held.
  always_ff @(posedge clk_i or posedge a_reset_h_i) begin
    if (a_reset_h_i) begin
      ptr         <= LS_FIRST;
      owner       <= PORT_IF;
      err_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if (grant) begin
        owner       <= sel;
        err_q       <= bad;
        bus_we_q    <= sel == PORT_LS && bus.ls_we_i;
        bus_size_q  <= sel == PORT_LS ? bus.ls_size_i : SZ_WORD;
        bus_addr_q  <= sel == PORT_LS ? bus.ls_addr_i : bus.if_addr_i;
        bus_wdata_q <= sel == PORT_LS ? bus.ls_wdata_i : '0;
        if (tie) ptr <= ~sel;
      end
      // A timeout returns 0 as data; a normal completion only updates rdata on reads.
      if ((state == ST_XFER && bus.bus_rdy_i && !bus_we_q) || expired) begin
        if (owner == PORT_LS) ls_rdata_q <= expired ? '0 : bus.bus_read_data_i;
        else if_rdata_q <= expired ? '0 : bus.bus_read_data_i;
      end
      if (expired) err_q <= 1'b1;
    end
  end
  assign bus.if_gnt_o         = grant && sel == PORT_IF && !a_reset_h_i;
  assign bus.ls_gnt_o         = grant && sel == PORT_LS && !a_reset_h_i;
  assign bus.if_done_o        = state == ST_RESP && owner == PORT_IF;
  assign bus.ls_done_o        = state == ST_RESP && owner == PORT_LS;
  assign bus.if_err_o         = bus.if_done_o && err_q;
  assign bus.ls_err_o         = bus.ls_done_o && err_q;
  assign bus.if_rdata_o       = if_rdata_q;
  assign bus.ls_rdata_o       = ls_rdata_q;
  assign bus.bus_en_o         = state == ST_XFER;
  assign bus.bus_we_o         = bus_we_q;
  assign bus.bus_size_o       = bus_size_q;
  assign bus.bus_addr_o       = bus_addr_q;
  assign bus.bus_write_data_o = bus_wdata_q;
  assign bus.busy_o           = state != ST_IDLE;
endmodule

// File: tb/tb_dobby_bus_arbiter.sv
// tb_dobby_bus_arbiter: self-checking bench for dobby_bus_arbiter
module tb_dobby_bus_arbiter;
  import dobby_bus_pkg::*;
  localparam int AW = 16;
  localparam int DW = 32;
  typedef struct {
    logic          we;
    logic [1:0]    sz;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            dly;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] m_if_rd, m_ls_rd;
  logic m_ptr;
  vec_t vt [9];
  always #5 clk_i = ~clk_i;
  dobby_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();
  dobby_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8), .LS_FIRST(1'b1)) dut (
    .clk_i(clk_i),
    .a_reset_h_i(rst),
    .bus(b)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic clear_inputs();
    b.if_req_i = 1'b0;
    b.if_addr_i = '0;
    b.ls_req_i = 1'b0;
    b.ls_we_i = 1'b0;
    b.ls_size_i = '0;
    b.ls_addr_i = '0;
    b.ls_wdata_i = '0;
    b.bus_rdy_i = 1'b0;
    b.bus_read_data_i = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cyc();
    rst = 1'b0;
    m_if_rd = '0;
    m_ls_rd = '0;
    m_ptr = 1'b1;
  endtask
  task automatic set_port(input logic is_ls, input logic we, input logic [1:0] sz,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (is_ls) begin
      b.ls_req_i = 1'b1;
      b.ls_we_i = we;
      b.ls_size_i = sz;
      b.ls_addr_i = addr;
      b.ls_wdata_i = wd;
    end else begin
      b.if_req_i = 1'b1;
      b.if_addr_i = addr;
    end
  endtask
  // Access legality from first principles: an access of N bytes must sit on an N-byte boundary.
  function automatic logic bad_align(input logic is_ls, input logic [1:0] sz, input logic [AW-1:0] addr);
    int bytes;
    if (!is_ls) return addr % 4 != 0;
    if (sz == 2'd3) return 1'b1;
    bytes = 1 << sz;
    return addr % bytes != 0;
  endfunction
  // Starts in an IDLE cycle; grant now, dly+1 bus cycles unless rejected, then the response cycle.
  task automatic run_one(input logic is_ls, input logic we, input logic [1:0] sz, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int dly,
                         input logic exp_err, input logic [DW-1:0] exp_rdata, input string tag);
    set_port(is_ls, we, sz, addr, wd);
    b.bus_rdy_i = 1'b0;
    #3;
    chk({tag, ".gnt"}, is_ls ? b.ls_gnt_o : b.if_gnt_o, 1'b1);
    chk({tag, ".gnt_other"}, is_ls ? b.if_gnt_o : b.ls_gnt_o, 1'b0);
    chk({tag, ".en_at_gnt"}, b.bus_en_o, 1'b0);
    next_cyc();
    if (!exp_err)
      for (int i = 0; i <= dly; i++) begin
        b.bus_rdy_i = i == dly;
        b.bus_read_data_i = i == dly ? rd : DW'($urandom);
        #3;
        chk({tag, ".en"}, b.bus_en_o, 1'b1);
        chk({tag, ".done_early"}, b.if_done_o | b.ls_done_o, 1'b0);
        if (i == 0) begin
          chk({tag, ".addr"}, b.bus_addr_o, addr);
          chk({tag, ".we"}, b.bus_we_o, is_ls & we);
          chk({tag, ".size"}, b.bus_size_o, is_ls ? sz : SZ_WORD);
          if (is_ls && we) chk({tag, ".wdata"}, b.bus_write_data_o, wd);
        end
        next_cyc();
      end
    b.bus_rdy_i = 1'b0;
    #3;
    chk({tag, ".en_resp"}, b.bus_en_o, 1'b0);
    chk({tag, ".done"}, is_ls ? b.ls_done_o : b.if_done_o, 1'b1);
    chk({tag, ".done_other"}, is_ls ? b.if_done_o : b.ls_done_o, 1'b0);
    chk({tag, ".err"}, is_ls ? b.ls_err_o : b.if_err_o, exp_err);
    chk({tag, ".rdata"}, is_ls ? b.ls_rdata_o : b.if_rdata_o, exp_rdata);
    if (is_ls) b.ls_req_i = 1'b0;
    else b.if_req_i = 1'b0;
    next_cyc();
  endtask
  task automatic model_txn(input logic is_ls, input logic we, input logic [1:0] sz, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int dly, input string tag);
    logic e;
    logic [DW-1:0] er;
    e = bad_align(is_ls, sz, addr);
    er = is_ls ? m_ls_rd : m_if_rd;
    if (!e && !(is_ls && we)) er = rd;
    run_one(is_ls, we, sz, addr, wd, rd, dly, e, er, tag);
    if (is_ls) m_ls_rd = er;
    else m_if_rd = er;
  endtask
  task automatic rand_iter(input int it);
    int pat, idly, ldly;
    logic first_ls, we;
    logic [1:0] sz;
    logic [AW-1:0] ia, la;
    logic [DW-1:0] wd, ird, lrd;
    pat = $urandom_range(1, 3);
    ia = AW'($urandom);
    if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
    la = AW'($urandom);
    if ($urandom_range(0, 2) != 0) la[1:0] = 2'b00;
    sz = 2'($urandom);
    we = 1'($urandom);
    wd = $urandom;
    ird = $urandom;
    lrd = $urandom;
    idly = $urandom_range(0, 3);
    ldly = $urandom_range(0, 3);
    first_ls = pat == 3 ? m_ptr : pat == 2;
    if (pat == 3) begin
      set_port(!first_ls, we, sz, first_ls ? ia : la, wd);
      m_ptr = !first_ls;
    end
    model_txn(first_ls, we, sz, first_ls ? la : ia, wd, first_ls ? lrd : ird, first_ls ? ldly : idly,
              $sformatf("rnd%0d.a", it));
    if (pat == 3)
      model_txn(!first_ls, we, sz, first_ls ? ia : la, wd, first_ls ? ird : lrd, first_ls ? idly : ldly,
                $sformatf("rnd%0d.b", it));
  endtask
  initial begin
    int n;
    logic exp_ls, saw;
    vt[0] = '{1'b1, 2'b01, 16'h0203, 32'h0000_1111, 32'h0, 0, 1'b1, 32'h0};
    vt[1] = '{1'b1, 2'b11, 16'h0200, 32'h0000_2222, 32'h0, 0, 1'b1, 32'h0};
    vt[2] = '{1'b1, 2'b00, 16'h0010, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1'b0, 32'h0};
    vt[3] = '{1'b0, 2'b10, 16'h0204, 32'h0, 32'h1122_3344, 1, 1'b0, 32'h1122_3344};
    vt[4] = '{1'b0, 2'b01, 16'h0102, 32'h0, 32'h0000_CAFE, 0, 1'b0, 32'h0000_CAFE};
    vt[5] = '{1'b0, 2'b10, 16'h0102, 32'h0, 32'h5555_5555, 0, 1'b1, 32'h0000_CAFE};
    vt[6] = '{1'b0, 2'b00, 16'h0007, 32'h0, 32'h0000_0077, 2, 1'b0, 32'h0000_0077};
    vt[7] = '{1'b0, 2'b01, 16'h0001, 32'h0, 32'h6666_6666, 0, 1'b1, 32'h0000_0077};
    vt[8] = '{1'b1, 2'b10, 16'h0300, 32'h1234_5678, 32'h9999_9999, 1, 1'b0, 32'h0000_0077};
    clear_inputs();
    m_if_rd = '0;
    m_ls_rd = '0;
    m_ptr = 1'b1;
    next_cyc();
    #3;
    chk("rst.busy", b.busy_o, 1'b0);
    chk("rst.en", b.bus_en_o, 1'b0);
    chk("rst.done", {b.if_done_o, b.ls_done_o, b.if_err_o, b.ls_err_o}, 4'b0);
    chk("rst.rdata", {b.if_rdata_o, b.ls_rdata_o}, 64'h0);
    chk("rst.bus", {b.bus_we_o, b.bus_size_o, b.bus_addr_o, b.bus_write_data_o}, '0);
    next_cyc();
    rst = 1'b0;
    model_txn(1'b0, 1'b0, SZ_WORD, 16'h0100, 32'h0, 32'hDEAD_BEEF, 1, "t1");
    chk("t1.rdata_val", b.if_rdata_o, 32'hDEAD_BEEF);
    do_reset();
    set_port(1'b1, 1'b0, SZ_WORD, 16'h0020, 32'h0);
    set_port(1'b0, 1'b0, SZ_WORD, 16'h0030, 32'h0);
    b.bus_rdy_i = 1'b1;
    n = 0;
    exp_ls = 1'b1;
    for (int c = 0; c < 20 && n < 6; c++) begin
      #3;
      if (b.if_gnt_o | b.ls_gnt_o) begin
        chk($sformatf("t2.gnt%0d", n), {b.ls_gnt_o, b.if_gnt_o}, exp_ls ? 2'b10 : 2'b01);
        exp_ls = !exp_ls;
        n++;
      end
      next_cyc();
    end
    chk("t2.count", n, 6);
    b.if_req_i = 1'b0;
    b.ls_req_i = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_one(1'b1, vt[i].we, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].dly,
              vt[i].exp_err, vt[i].exp_rdata, $sformatf("vec%0d", i));
      m_ls_rd = vt[i].exp_rdata;
    end
    do_reset();
    set_port(1'b0, 1'b0, SZ_WORD, 16'h0040, 32'h0);
    #3;
    chk("t5.gnt", b.if_gnt_o, 1'b1);
    next_cyc();
    #3;
    chk("t5.en", b.bus_en_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5.en_drop", b.bus_en_o, 1'b0);
    chk("t5.busy_drop", b.busy_o, 1'b0);
    b.if_req_i = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    m_if_rd = '0;
    m_ls_rd = '0;
    m_ptr = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      if (b.if_done_o | b.ls_done_o | b.busy_o) saw = 1'b1;
      next_cyc();
    end
    chk("t5.no_done", saw, 1'b0);
    model_txn(1'b0, 1'b0, SZ_WORD, 16'h0044, 32'h0, 32'h5A5A_A5A5, 0, "t5.after");
    do_reset();
    for (int it = 0; it < 40; it++) rand_iter(it);
    set_port(1'b0, 1'b0, SZ_WORD, 16'h0080, 32'h0);
    b.bus_rdy_i = 1'b0;
    #3;
    chk("t6.gnt", b.if_gnt_o, 1'b1);
    next_cyc();
`ifdef DOBBY_BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("t6.en%0d", i), {b.bus_en_o, b.if_done_o}, 2'b10);
      next_cyc();
    end
    #3;
    chk("t6.en_drop", b.bus_en_o, 1'b0);
    chk("t6.done", b.if_done_o, 1'b1);
    chk("t6.err", b.if_err_o, 1'b1);
    chk("t6.rdata", b.if_rdata_o, 32'h0);
    b.if_req_i = 1'b0;
    next_cyc();
`else
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (!b.bus_en_o || b.if_done_o) saw = 1'b1;
      next_cyc();
    end
    chk("t6.hang", saw, 1'b0);
    do_reset();
    #3;
    chk("t6.en_after_rst", b.bus_en_o, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
